// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// opcode classes and the ALU-op / ALU source-B select codes used by the datapath.
package rv_ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned STATE_W = 4;

  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_TRAP     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: free-running up-counter, wraps silently.
module retire_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/memory/write-back,
// stalls on mem_ready, traps on illegal opcodes and counts retired instructions.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned OP_WIDTH  = 7,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_WIDTH-1:0]  op,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 ir_write,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  state_t    state;
  state_t    state_n;
  op_class_t op_class;
  op_class_t dec_class;
  logic      retire_inc;

  // Opcode classification, only consumed while in DECODE
  always_comb begin
    dec_class = CLS_ILLEGAL;
    if      (op == OP_WIDTH'(OPC_R))      dec_class = CLS_R;
    else if (op == OP_WIDTH'(OPC_I))      dec_class = CLS_I;
    else if (op == OP_WIDTH'(OPC_LOAD))   dec_class = CLS_LOAD;
    else if (op == OP_WIDTH'(OPC_STORE))  dec_class = CLS_STORE;
    else if (op == OP_WIDTH'(OPC_BRANCH)) dec_class = CLS_BRANCH;
  end

  // State register; the class is latched so MEM_ADDR never re-reads op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_class <= CLS_ILLEGAL;
    end else begin
      state <= state_n;
      if (state == ST_DECODE) begin
        op_class <= dec_class;
      end
    end
  end

  // Next state and Moore outputs (FETCH also looks at mem_ready)
  always_comb begin
    state_n       = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    halted        = 1'b0;
    retire_inc    = 1'b0;

    case (state)
      ST_IDLE: begin
        state_n = ST_FETCH;
      end
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_n = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM;
        case (dec_class)
          CLS_R:      state_n = ST_EXEC_R;
          CLS_I:      state_n = ST_EXEC_I;
          CLS_LOAD,
          CLS_STORE:  state_n = ST_MEM_ADDR;
          CLS_BRANCH: state_n = ST_BRANCH;
          default:    state_n = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_RTYPE;
        state_n   = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ITYPE;
        state_n   = ST_WB_ALU;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_n   = (op_class == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_n = ST_WB_MEM;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_n    = ST_FETCH;
          retire_inc = 1'b1;
        end
      end
      ST_WB_ALU: begin
        reg_write  = 1'b1;
        state_n    = ST_FETCH;
        retire_inc = 1'b1;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_n    = ST_FETCH;
        retire_inc = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        state_n       = ST_FETCH;
        retire_inc    = 1'b1;
      end
      ST_TRAP: begin
        halted = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  retire_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (retire_inc),
    .count (retired)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control-vector checks against
// hand-derived per-state values, plus retire count, trap, async reset and wrap.
module tb_multicycle_control;

  // Control vector: {pw, pwc, irw, iord, mrd, mwr, m2r, rw, asa, asb[1:0], aop[1:0], halted}
  localparam logic [13:0] V_IDLE    = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [13:0] V_FETCH1  = 14'b1_0_1_0_1_0_0_0_0_01_00_0;
  localparam logic [13:0] V_FETCH0  = 14'b0_0_0_0_1_0_0_0_0_01_00_0;
  localparam logic [13:0] V_DECODE  = 14'b0_0_0_0_0_0_0_0_0_10_00_0;
  localparam logic [13:0] V_EXEC_R  = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [13:0] V_EXEC_I  = 14'b0_0_0_0_0_0_0_0_1_10_11_0;
  localparam logic [13:0] V_MADDR   = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [13:0] V_MEMRD   = 14'b0_0_0_1_1_0_0_0_0_00_00_0;
  localparam logic [13:0] V_MEMWR   = 14'b0_0_0_1_0_1_0_0_0_00_00_0;
  localparam logic [13:0] V_WB_ALU  = 14'b0_0_0_0_0_0_0_1_0_00_00_0;
  localparam logic [13:0] V_WB_MEM  = 14'b0_0_0_0_0_0_1_1_0_00_00_0;
  localparam logic [13:0] V_BRANCH  = 14'b0_1_0_0_0_0_0_0_1_00_01_0;
  localparam logic [13:0] V_TRAP    = 14'b0_0_0_0_0_0_0_0_0_00_00_1;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic        mem_ready;

  logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0]  alu_src_b, alu_op;
  logic [31:0] retired;

  logic        n_pc_write, n_pc_write_cond, n_ir_write, n_i_or_d, n_mem_read, n_mem_write;
  logic        n_mem_to_reg, n_reg_write, n_alu_src_a, n_halted;
  logic [1:0]  n_alu_src_b, n_alu_op;
  logic [3:0]  n_retired;

  logic [13:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, halted};

  int total = 0;
  int bad   = 0;

  multicycle_control #(.OP_WIDTH(7), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted), .retired(retired)
  );

  // Narrow-counter instance shares all stimulus to exercise wrap-around
  multicycle_control #(.OP_WIDTH(7), .CNT_WIDTH(4)) dut_narrow (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .ir_write(n_ir_write),
    .i_or_d(n_i_or_d), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .halted(n_halted), .retired(n_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive mem_ready, check control vector mid-cycle, advance
  task automatic step(input string tag, input logic mr, input logic [13:0] exp);
    mem_ready = mr;
    @(negedge clk);
    check(tag, 32'(ctrl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    op        = 7'd0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(V_IDLE));
    check("rst_retired", retired, 32'd0);
    reset = 1'b0;

    // R-type
    op = OP_R;
    step("r_idle",  1'b1, V_IDLE);
    step("r_fetch", 1'b1, V_FETCH1);
    step("r_dec",   1'b1, V_DECODE);
    step("r_exec",  1'b1, V_EXEC_R);
    check("r_ret_before_wb", retired, 32'd0);
    step("r_wb",    1'b1, V_WB_ALU);
    check("r_ret", retired, 32'd1);

    // LOAD with 3 stall cycles in MEM_RD: 8 cycles FETCH..WB_MEM
    op = OP_LD;
    step("ld_fetch", 1'b1, V_FETCH1);
    step("ld_dec",   1'b1, V_DECODE);
    step("ld_addr",  1'b1, V_MADDR);
    step("ld_rd0",   1'b0, V_MEMRD);
    step("ld_rd1",   1'b0, V_MEMRD);
    step("ld_rd2",   1'b0, V_MEMRD);
    step("ld_rd3",   1'b1, V_MEMRD);
    step("ld_wb",    1'b1, V_WB_MEM);
    check("ld_ret", retired, 32'd2);

    // STORE; op changed after DECODE must not redirect MEM_ADDR
    op = OP_ST;
    step("st_fetch", 1'b1, V_FETCH1);
    step("st_dec",   1'b1, V_DECODE);
    op = OP_LD;
    step("st_addr",  1'b1, V_MADDR);
    step("st_wr",    1'b1, V_MEMWR);
    check("st_ret", retired, 32'd3);

    // BRANCH back-to-back
    op = OP_BR;
    step("br_fetch", 1'b1, V_FETCH1);
    step("br_dec",   1'b0, V_DECODE);
    step("br_exec",  1'b1, V_BRANCH);
    check("br_ret", retired, 32'd4);

    // I-type with one FETCH stall
    op = OP_I;
    step("i_fetch0", 1'b0, V_FETCH0);
    step("i_fetch1", 1'b1, V_FETCH1);
    step("i_dec",    1'b1, V_DECODE);
    step("i_exec",   1'b0, V_EXEC_I);
    step("i_wb",     1'b1, V_WB_ALU);
    check("i_ret", retired, 32'd5);

    // Illegal opcode: sticky TRAP
    op = OP_BAD;
    step("bad_fetch", 1'b1, V_FETCH1);
    step("bad_dec",   1'b1, V_DECODE);
    op = OP_R;
    for (int i = 0; i < 20; i++) begin
      step("trap_hold", 1'(i), V_TRAP);
    end
    check("trap_ret", retired, 32'd5);

    reset = 1'b1;
    #1;
    check("trap_rst_ctrl", 32'(ctrl), 32'(V_IDLE));
    check("trap_rst_ret", retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 17 R-type: narrow counter wraps 15 -> 0 and ends at 1
    op = OP_R;
    step("w_idle", 1'b1, V_IDLE);
    for (int n = 0; n < 17; n++) begin
      step("w_fetch", 1'b1, V_FETCH1);
      step("w_dec",   1'b1, V_DECODE);
      step("w_exec",  1'b1, V_EXEC_R);
      step("w_wb",    1'b1, V_WB_ALU);
      check("w_ret", retired, 32'(n + 1));
      check("w_ret_narrow", 32'(n_retired), 32'((n + 1) % 16));
    end

    // Async reset in the middle of a stalled MEM_WR
    op = OP_ST;
    step("ar_fetch", 1'b1, V_FETCH1);
    step("ar_dec",   1'b1, V_DECODE);
    step("ar_addr",  1'b1, V_MADDR);
    step("ar_wr",    1'b0, V_MEMWR);
    #2;
    check("ar_pre_ctrl", 32'(ctrl), 32'(V_MEMWR));
    reset = 1'b1;
    #1;
    check("ar_ctrl", 32'(ctrl), 32'(V_IDLE));
    check("ar_ret", retired, 32'd0);
    check("ar_ret_narrow", 32'(n_retired), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("ar_idle",  1'b1, V_IDLE);
    step("ar_fetch2", 1'b1, V_FETCH1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
